// File: rtl/fb_rect_filler.sv
// Rectangle-fill engine for the VGA framebuffer write port.
// Accepts one fill command at a time, clips it to the visible area and streams
// one pixel write per clock in row-major order, then pulses done_o.
module fb_rect_filler #(
   parameter int VGA_WIDTH  = 640,
   parameter int VGA_HEIGHT = 480,
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 19,
   parameter int X_W        = $clog2(VGA_WIDTH),
   parameter int Y_W        = $clog2(VGA_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [X_W-1:0]        cmd_x0_i,
   input  logic [Y_W-1:0]        cmd_y0_i,
   input  logic [X_W:0]          cmd_w_i,
   input  logic [Y_W:0]          cmd_h_i,
   input  logic [DATA_WIDTH-1:0] cmd_color_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_FILL,
      S_DONE
   } state_e;

   // Screen limits at the widths used for the clip comparisons.
   localparam logic [X_W:0]          WIDTH_X  = (X_W + 1)'(VGA_WIDTH);
   localparam logic [Y_W:0]          HEIGHT_Y = (Y_W + 1)'(VGA_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(VGA_WIDTH);

   state_e                state_q, state_d;

   // Latched command fields.
   logic [X_W-1:0]        x0_q, x0_d;
   logic [Y_W-1:0]        y0_q, y0_d;
   logic [X_W:0]          w_q, w_d;
   logic [Y_W:0]          h_q, h_d;
   logic [DATA_WIDTH-1:0] color_q, color_d;

   // Clipped extent and fill cursor.
   logic [X_W:0]          ew_q, ew_d;
   logic [Y_W:0]          eh_q, eh_d;
   logic [X_W:0]          col_q, col_d;
   logic [Y_W:0]          row_q, row_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

   // Registered outputs.
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   // Clip helpers, only meaningful while in SETUP.
   logic [X_W:0]          room_x, clip_w;
   logic [Y_W:0]          room_y, clip_h;
   logic [ADDR_WIDTH-1:0] base_calc;
   logic                  last_col, last_row;

   // Clip the latched rectangle to the screen and form the first-row address.
   always_comb begin
      room_x = WIDTH_X - {1'b0, x0_q};
      room_y = HEIGHT_Y - {1'b0, y0_q};

      if ({1'b0, x0_q} >= WIDTH_X) begin
         clip_w = '0;
      end else if (w_q < room_x) begin
         clip_w = w_q;
      end else begin
         clip_w = room_x;
      end

      if ({1'b0, y0_q} >= HEIGHT_Y) begin
         clip_h = '0;
      end else if (h_q < room_y) begin
         clip_h = h_q;
      end else begin
         clip_h = room_y;
      end

      // The only multiply in the engine; FILL walks rows by adding STRIDE.
      base_calc = ADDR_WIDTH'(y0_q) * STRIDE + ADDR_WIDTH'(x0_q);

      last_col = (col_q == ew_q - (X_W + 1)'(1));
      last_row = (row_q == eh_q - (Y_W + 1)'(1));
   end

   // Next-state and next-output logic for the fill sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; that is what keeps this block free of inferred latches.
      state_d    = state_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      w_d        = w_q;
      h_d        = h_q;
      color_d    = color_q;
      ew_d       = ew_q;
      eh_d       = eh_q;
      col_d      = col_q;
      row_d      = row_q;
      row_base_d = row_base_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i && ready_q) begin
               x0_d    = cmd_x0_i;
               y0_d    = cmd_y0_i;
               w_d     = cmd_w_i;
               h_d     = cmd_h_i;
               color_d = cmd_color_i;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            ew_d       = clip_w;
            eh_d       = clip_h;
            row_base_d = base_calc;
            col_d      = '0;
            row_d      = '0;
            if (clip_w == '0 || clip_h == '0) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // First pixel is presented on the very next cycle.
               wr_en_d   = 1'b1;
               wr_addr_d = base_calc;
               wr_data_d = color_q;
               state_d   = S_FILL;
            end
         end

         S_FILL: begin
            // col_q/row_q describe the pixel being written this cycle.
            if (last_col && last_row) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (last_col) begin
               col_d      = '0;
               row_d      = row_q + (Y_W + 1)'(1);
               row_base_d = row_base_q + STRIDE;
               wr_en_d    = 1'b1;
               wr_addr_d  = row_base_d;
            end else begin
               col_d     = col_q + (X_W + 1)'(1);
               wr_en_d   = 1'b1;
               wr_addr_d = row_base_q + ADDR_WIDTH'(col_d);
            end
         end

         S_DONE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // the pre-edge value, independent of statement order.
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers; reset drops the write strobe immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         color_q    <= '0;
         ew_q       <= '0;
         eh_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         w_q        <= w_d;
         h_q        <= h_d;
         color_q    <= color_d;
         ew_q       <= ew_d;
         eh_q       <= eh_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_base_q <= row_base_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign cmd_ready_o = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign wr_en_o     = wr_en_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;

endmodule
